// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-length packet from a FIFO read port
// into a valid/ready stream with last framing, via a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  pkt_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_dat_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  last_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  fetched_q;
    logic                  done_q;

    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  last0_q, last0_d;
    logic                  last1_q, last1_d;

    logic pop;
    logic hs;
    logic push_last;

    // Pop only needs free buffer space; the sink's ready never gates it.
    assign pop = (state_q == RUN) & ~fifo_empty_i & (fetched_q < len_q)
               & ~cnt_q[1] & ~flush_i & ~rst_i;
    assign hs        = (cnt_q != 2'd0) & ready_i;
    assign push_last = (fetched_q == len_q - LEN_WIDTH'(1));

    assign busy_o     = (state_q == RUN);
    assign done_o     = done_q;
    assign fifo_pop_o = pop;
    assign valid_o    = (cnt_q != 2'd0);
    assign dat_o      = buf0_q;
    assign last_o     = last0_q;

    // Buffer next state: entry 0 is always the oldest word.
    always_comb begin
        cnt_d   = cnt_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case (cnt_q)
            2'd0: begin
                if (pop) begin
                    buf0_d  = fifo_dat_i;
                    last0_d = push_last;
                    cnt_d   = 2'd1;
                end
            end
            2'd1: begin
                if (pop && hs) begin
                    buf0_d  = fifo_dat_i;
                    last0_d = push_last;
                end else if (pop) begin
                    buf1_d  = fifo_dat_i;
                    last1_d = push_last;
                    cnt_d   = 2'd2;
                end else if (hs) begin
                    last0_d = 1'b0;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                if (hs) begin
                    buf0_d  = buf1_q;
                    last0_d = last1_q;
                    cnt_d   = 2'd1;
                end
            end
        endcase
        if (flush_i) begin
            cnt_d   = 2'd0;
            buf0_d  = '0;
            last0_d = 1'b0;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

    // Packet FSM: length latch, fetch counter and done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            fetched_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && pkt_len_i != '0) begin
                            state_q   <= RUN;
                            len_q     <= pkt_len_i;
                            fetched_q <= '0;
                        end
                    end
                    default: begin
                        if (pop) fetched_q <= fetched_q + LEN_WIDTH'(1);
                        if (hs && last0_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed table and sequence checks for
// fifo_stream_reader against a simple FIFO model.
module tb_fifo_stream_reader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        start_i;
    logic [15:0] pkt_len_i;
    logic        busy_o;
    logic        done_o;
    logic        fifo_empty_i;
    logic [31:0] fifo_dat_i;
    logic        fifo_pop_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] dat_o;
    logic        last_o;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] mem [16];
    int          wr_cnt = 0;
    int          rd_idx = 0;
    logic        fifo_clr = 1'b0;
    logic        force_empty = 1'b0;

    logic [31:0] got [$];
    logic        gotl [$];
    int          done_cnt;
    int          bad_pop;

    always #5 clk_i = ~clk_i;

    assign fifo_empty_i = force_empty | (rd_idx >= wr_cnt);
    assign fifo_dat_i   = mem[rd_idx[3:0]];

    always @(posedge clk_i) begin
        if (fifo_clr) rd_idx <= 0;
        else if (fifo_pop_o) rd_idx <= rd_idx + 1;
    end

    fifo_stream_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .start_i(start_i), .pkt_len_i(pkt_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .fifo_empty_i(fifo_empty_i), .fifo_dat_i(fifo_dat_i),
        .fifo_pop_o(fifo_pop_o), .valid_o(valid_o), .ready_i(ready_i),
        .dat_o(dat_o), .last_o(last_o)
    );

    typedef struct {
        logic        start;
        logic [15:0] len;
        logic        e_pop;
        logic        e_valid;
        logic [31:0] e_dat;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base);
        for (int i = 0; i < 16; i++) mem[i] = base + 32'(i);
        wr_cnt   = n;
        fifo_clr = 1'b1;
        @(negedge clk_i);
        fifo_clr = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] len);
        start_i   = 1'b1;
        pkt_len_i = len;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic drain(input int maxc, input bit tog);
        got.delete();
        gotl.delete();
        done_cnt = 0;
        bad_pop  = 0;
        for (int c = 0; c < maxc; c++) begin
            ready_i = 1'b1;
            force_empty = tog ? (c % 2 == 0) : 1'b0;
            #1;
            if (fifo_pop_o && fifo_empty_i) bad_pop++;
            if (valid_o && ready_i) begin
                got.push_back(dat_o);
                gotl.push_back(last_o);
            end
            if (done_o) done_cnt++;
            @(negedge clk_i);
        end
        force_empty = 1'b0;
    endtask

    task automatic chk_words(input string nm, input int n,
                             input logic [31:0] base);
        chk({nm, " count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("%s dat%0d", nm, i), got[i], base + 32'(i));
            chk($sformatf("%s last%0d", nm, i), 32'(gotl[i]),
                32'(i == n - 1));
        end
        chk({nm, " done"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    int pops;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; start_i = 1'b0;
        pkt_len_i = '0; ready_i = 1'b1;
        tbl[0] = '{1, 16'd4, 0, 0, 32'h0, 0, 0, 0};
        tbl[1] = '{0, 16'd0, 1, 0, 32'h0, 0, 1, 0};
        tbl[2] = '{0, 16'd0, 1, 1, 32'hA000_0000, 0, 1, 0};
        tbl[3] = '{0, 16'd0, 1, 1, 32'hA000_0001, 0, 1, 0};
        tbl[4] = '{0, 16'd0, 1, 1, 32'hA000_0002, 0, 1, 0};
        tbl[5] = '{0, 16'd0, 0, 1, 32'hA000_0003, 1, 1, 0};
        tbl[6] = '{0, 16'd0, 0, 0, 32'h0, 0, 0, 1};
        tbl[7] = '{0, 16'd0, 0, 0, 32'h0, 0, 0, 0};

        // reset values
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst busy", 32'(busy_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst valid", 32'(valid_o), 0);
        chk("rst dat", dat_o, 0);
        chk("rst last", 32'(last_o), 0);
        chk("rst pop", 32'(fifo_pop_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // test 1: table-driven len=4 with ready held high
        load(4, 32'hA000_0000);
        for (int i = 0; i < 8; i++) begin
            start_i   = tbl[i].start;
            pkt_len_i = tbl[i].len;
            ready_i   = 1'b1;
            #1;
            chk($sformatf("t1 c%0d pop", i), 32'(fifo_pop_o),
                32'(tbl[i].e_pop));
            chk($sformatf("t1 c%0d valid", i), 32'(valid_o),
                32'(tbl[i].e_valid));
            chk($sformatf("t1 c%0d busy", i), 32'(busy_o),
                32'(tbl[i].e_busy));
            chk($sformatf("t1 c%0d done", i), 32'(done_o),
                32'(tbl[i].e_done));
            if (tbl[i].e_valid) begin
                chk($sformatf("t1 c%0d dat", i), dat_o, tbl[i].e_dat);
                chk($sformatf("t1 c%0d last", i), 32'(last_o),
                    32'(tbl[i].e_last));
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;

        // test 2: backpressure, buffer fills after two pops
        load(6, 32'hB000_0000);
        ready_i = 1'b0;
        do_start(16'd6);
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (fifo_pop_o) pops++;
            @(negedge clk_i);
        end
        #1;
        chk("t2 pops", 32'(pops), 32'd2);
        chk("t2 pop now", 32'(fifo_pop_o), 0);
        chk("t2 valid", 32'(valid_o), 1);
        chk("t2 dat", dat_o, 32'hB000_0000);
        drain(15, 1'b0);
        chk_words("t2", 6, 32'hB000_0000);

        // test 3: FIFO empty toggling
        load(5, 32'hC000_0000);
        do_start(16'd3);
        drain(20, 1'b1);
        chk_words("t3", 3, 32'hC000_0000);
        chk("t3 pop while empty", 32'(bad_pop), 0);
        chk("t3 fifo rd", 32'(rd_idx), 32'd3);

        // test 4: flush after two handshakes
        load(8, 32'hD000_0000);
        ready_i = 1'b1;
        do_start(16'd8);
        pops = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (valid_o) pops++;
            @(negedge clk_i);
        end
        chk("t4 handshakes", 32'(pops), 32'd2);
        flush_i = 1'b1;
        #1;
        chk("t4 pop in flush", 32'(fifo_pop_o), 0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        chk("t4 valid", 32'(valid_o), 0);
        chk("t4 busy", 32'(busy_o), 0);
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (done_o) done_cnt++;
            @(negedge clk_i);
        end
        chk("t4 done", 32'(done_cnt), 0);
        chk("t4 fifo rd", 32'(rd_idx), 32'd3);

        // test 5: zero length, then len=1 with start during RUN
        load(3, 32'hE000_0000);
        do_start(16'd0);
        #1;
        chk("t5 len0 busy", 32'(busy_o), 0);
        chk("t5 len0 pop", 32'(fifo_pop_o), 0);
        @(negedge clk_i);
        do_start(16'd1);
        do_start(16'd5);
        drain(10, 1'b0);
        got.push_front(32'hE000_0000);
        gotl.push_front(1'b1);
        chk("t5 first word seen", 32'(got.size() >= 2 ? got[1] : 0),
            32'hE000_0000);
        void'(got.pop_front());
        void'(gotl.pop_front());
        chk_words("t5", 1, 32'hE000_0000);
        chk("t5 fifo rd", 32'(rd_idx), 32'd1);

        // test 6: reset mid-packet with two words buffered
        load(6, 32'hF000_0000);
        ready_i = 1'b0;
        do_start(16'd6);
        for (int c = 0; c < 4; c++) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t6 pop in rst", 32'(fifo_pop_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("t6 busy", 32'(busy_o), 0);
        chk("t6 done", 32'(done_o), 0);
        chk("t6 valid", 32'(valid_o), 0);
        chk("t6 dat", dat_o, 0);
        chk("t6 last", 32'(last_o), 0);
        chk("t6 pop", 32'(fifo_pop_o), 0);
        for (int c = 0; c < 4; c++) @(negedge clk_i);
        chk("t6 fifo rd", 32'(rd_idx), 32'd2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
